// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// State encodings are fixed so waveforms and debug taps stay stable.
package seq_divider_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_sub_borrow.sv
// Ripple subtractor a - b built from full-adder cells (b inverted, carry-in 1).
// Latency: combinational.
// Backpressure: none; pure datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// Parameterised W-bit subtractor; borrow is the inverted carry-out of the chain.
// Latency: combinational, W full-adder ripple.
// Backpressure: none; pure datapath.
module sub_borrow #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (~b[i]),
            .ci (carry[i]),
            .s  (diff[i]),
            .co (carry[i+1])
        );
    end

    // Carry-out of a + ~b + 1 is set exactly when a >= b.
    assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Latency: DW+1 cycles from accepted start to done; 1 cycle for divide-by-zero.
// Backpressure: start is honoured only while ready (IDLE or DONE); ignored while busy.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;

    state_t        state, state_nxt;
    logic [VW:0]   pr;
    logic [VW:0]   pr_sh;
    logic [VW:0]   diff;
    logic [VW:0]   pr_step;
    logic          borrow;
    logic [DW-1:0] sh;
    logic [DW-1:0] sh_step;
    logic [VW-1:0] dv;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          dv_zero;
    logic          last_step;

    assign accept    = start & ready;
    assign dv_zero   = (divisor == '0);
    assign last_step = (state == RUN) && (cnt == '0);

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign pr_sh = {pr[VW-1:0], sh[DW-1]};

    sub_borrow #(
        .W (VW + 1)
    ) u_sub (
        .a      (pr_sh),
        .b      ({1'b0, dv}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign pr_step = borrow ? pr_sh : diff;
    assign sh_step = {sh[DW-2:0], ~borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = dv_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    state_nxt = dv_zero ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers advance only in RUN; results load only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr        <= '0;
            sh        <= '0;
            dv        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            pr  <= '0;
            sh  <= dividend;
            dv  <= divisor;
            cnt <= CW'(DW - 1);
            if (dv_zero) begin
                quotient  <= '1;
                remainder <= '0;
                dbz       <= 1'b1;
            end
        end else if (state == RUN) begin
            pr  <= pr_step;
            sh  <= sh_step;
            cnt <= cnt - 1'b1;
            if (last_step) begin
                quotient  <= sh_step;
                remainder <= pr_step[VW-1:0];
                dbz       <= 1'b0;
            end
        end
    end

endmodule
